// File: rtl/datapath_pkg.sv
// Shared constants for the multiply datapath: select codes, op codes, coefficient ROM
// contents and the multiplier state type.
package datapath_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int ROM_DEPTH_DEF = 4;

  localparam logic [2:0] SEL_ZERO = 3'b000;
  localparam logic [2:0] SEL_X    = 3'b001;
  localparam logic [2:0] SEL_ROM  = 3'b010;
  localparam logic [2:0] SEL_SUM  = 3'b011;
  localparam logic [2:0] SEL_PROD = 3'b100;
  localparam logic [2:0] SEL_REG3 = 3'b101;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [7:0] COEF [ROM_DEPTH_DEF] = '{8'd3, 8'd5, 8'd7, 8'd2};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mult_state_e;

endpackage

// File: rtl/datapath_mult_mult_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// registered full-width product and a one-cycle done pulse on completion.
module mult_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mult_state_e        state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] product_reg, product_next;
  logic               done_reg, done_next;
  logic [2*WIDTH-1:0] acc_step;

  assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      product_reg <= product_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    product_next = product_reg;
    done_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mcand_next  = {{WIDTH{1'b0}}, a};
          mplier_next = b;
          acc_next    = '0;
          count_next  = '0;
          state_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + CW'(1);
        // Last partial product lands straight in the result register.
        if (count_reg == CW'(WIDTH - 1)) begin
          state_next   = ST_IDLE;
          product_next = acc_step;
          done_next    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy    = (state_reg == ST_RUN);
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: rtl/datapath_mult.sv
// Controller-facing datapath: three working registers, coefficient ROM, add/sub unit
// and an iterative multiplier with busy/done handshake. Result is reg3.
module datapath_mult
  import datapath_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int ROM_AW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  x_in,
  input  logic              load_reg1,
  input  logic              load_reg2,
  input  logic              load_reg3,
  input  logic [2:0]        mux_load_reg1,
  input  logic              op,
  input  logic              mux_control_sum_sub,
  input  logic [ROM_AW-1:0] mux_control_rom,
  input  logic              mul_start,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [WIDTH-1:0]  result,
  output logic              overflow
);

  logic [WIDTH-1:0]   reg1_reg, reg1_next;
  logic [WIDTH-1:0]   reg2_reg, reg2_next;
  logic [WIDTH-1:0]   reg3_reg, reg3_next;
  logic               ovf_reg, ovf_next;
  logic [WIDTH-1:0]   rom_words [ROM_DEPTH];
  logic [WIDTH-1:0]   rom_word;
  logic [WIDTH-1:0]   operand_b;
  logic [WIDTH:0]     alu_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH-1:0]   reg1_src;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_hi_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
      assign rom_words[gi] = WIDTH'(COEF[gi]);
    end
  endgenerate

  assign rom_word  = rom_words[mux_control_rom];
  assign operand_b = mux_control_sum_sub ? reg3_reg : reg2_reg;
  // Extra top bit is the carry for add and the borrow for sub.
  assign alu_ext   = (op == OP_SUB) ? ({1'b0, reg1_reg} - {1'b0, operand_b})
                                    : ({1'b0, reg1_reg} + {1'b0, operand_b});
  assign alu_res   = alu_ext[WIDTH-1:0];
  assign alu_carry = alu_ext[WIDTH];

  mult_seq #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (reg1_reg),
    .b       (reg2_reg),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_hi_ovf = mul_done && (mul_product[2*WIDTH-1:WIDTH] != '0);

  always_comb begin
    reg1_src = '0;
    case (mux_load_reg1)
      SEL_X:    reg1_src = x_in;
      SEL_ROM:  reg1_src = rom_word;
      SEL_SUM:  reg1_src = alu_res;
      SEL_PROD: reg1_src = mul_product[WIDTH-1:0];
      SEL_REG3: reg1_src = reg3_reg;
      default:  reg1_src = '0;
    endcase
  end

  always_comb begin
    reg1_next = reg1_reg;
    reg2_next = reg2_reg;
    reg3_next = reg3_reg;
    ovf_next  = ovf_reg | mul_hi_ovf;
    if (load_reg1) reg1_next = reg1_src;
    if (load_reg2) reg2_next = x_in;
    if (load_reg3) begin
      reg3_next = alu_res;
      ovf_next  = ovf_next | alu_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg1_reg <= '0;
      reg2_reg <= '0;
      reg3_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      reg1_reg <= reg1_next;
      reg2_reg <= reg2_next;
      reg3_reg <= reg3_next;
      ovf_reg  <= ovf_next;
    end
  end

  // The multiply overflow is visible in the done cycle itself, then held by ovf_reg.
  assign overflow = ovf_reg | mul_hi_ovf;
  assign result   = reg3_reg;

endmodule
